regfile_wb_scheduler: RTL and testbench

- Schedules the single register-file write port between two writers.
  - Primary: the in-order pipeline writeback stage. It has no backpressure and fixed priority.
  - Secondary: long-latency units (mul/div, uncached load), buffered in a small FIFO.
- Keeps a scoreboard of destination registers reserved by issued long-latency ops. From it, drives RAW/WAW stall requests to decode.
- Sits between writeback and the regfile. Its outputs drive the regfile wa3/wd3/write_enable inputs directly.

---
 rtl/regfile_wb_scheduler_pkg.sv | 20 ++
 rtl/regfile_wb_scheduler_wb_fifo.sv | 56 +++++
 rtl/regfile_wb_scheduler.sv | 112 +++++++++++
 tb/tb_regfile_wb_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types for the regfile writeback scheduler: register/word types,
// the buffered write request and the hard-wired zero register.
package regfile_wb_scheduler_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  creg_addr_t;

    typedef struct packed {
        creg_addr_t wa;
        word_t      wd;
    } wb_req_t;

    localparam creg_addr_t ZERO_REG = 5'd0;

    // Register 0 is never written and never reserved.
    function automatic logic is_zero_reg(input creg_addr_t a);
        return a == ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_wb_fifo.sv
// Small registered FIFO buffering secondary (long-latency) writeback requests.
// No bypass: an entry pushed at edge N is visible at the head from cycle N+1.
module wb_fifo
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    resetn,
    input  logic    i_push,
    input  wb_req_t i_din,
    input  logic    i_pop,
    output wb_req_t o_dout,
    output logic    o_full,
    output logic    o_empty
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    wb_req_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers wrap naturally; the extra count bit separates full from empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Regfile write-port scheduler: primary writeback has fixed priority, long-latency
// results drain from a FIFO in idle cycles. A busy scoreboard of reserved
// destinations drives decode hazard stalls; a starvation counter asks decode
// for a bubble when the FIFO has been blocked too long.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        p_valid,
    input  logic [4:0]  p_wa,
    input  logic [31:0] p_wd,
    input  logic        s_valid,
    input  logic [4:0]  s_wa,
    input  logic [31:0] s_wd,
    output logic        s_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_wa,
    output logic        iss_ready,
    input  logic [4:0]  q_ra1,
    input  logic [4:0]  q_ra2,
    input  logic [4:0]  q_wa,
    output logic        hazard_stall,
    output logic        starve_stall,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic        write_enable
);

    localparam int           SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [31:0]   r_busy;
    logic [SW-1:0] r_starve_cnt;
    wb_req_t       w_head;
    wb_req_t       w_s_req;
    logic          w_full;
    logic          w_empty;
    logic          w_p_sel;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_set;
    logic [31:0]   w_clr;

    assign w_s_req = '{wa: s_wa, wd: s_wd};
    // Primary path is masked in reset so the regfile sees no strobe.
    assign w_p_sel = p_valid && resetn;
    assign s_ready = !w_full;
    assign w_push  = s_valid && s_ready;
    assign w_pop   = !w_p_sel && !w_empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_din   (w_s_req),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Write-port mux: primary wins, else FIFO head, else idle.
    always_comb begin
        wa3          = ZERO_REG;
        wd3          = '0;
        write_enable = 1'b0;
        if (w_p_sel) begin
            wa3          = p_wa;
            wd3          = p_wd;
            write_enable = !is_zero_reg(p_wa);
        end else if (!w_empty) begin
            wa3          = w_head.wa;
            wd3          = w_head.wd;
            write_enable = !is_zero_reg(w_head.wa);
        end
    end

    // Reservation uses pre-edge busy, so a same-cycle release is not visible yet.
    assign iss_ready = !r_busy[iss_wa];

    assign hazard_stall = (r_busy[q_ra1] && !is_zero_reg(q_ra1)) ||
                          (r_busy[q_ra2] && !is_zero_reg(q_ra2)) ||
                          (r_busy[q_wa]  && !is_zero_reg(q_wa));

    // Set/clear masks for the scoreboard; register 0 is never tracked.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (iss_valid && iss_ready && !is_zero_reg(iss_wa)) w_set[iss_wa]    = 1'b1;
        if (w_pop && !is_zero_reg(w_head.wa))               w_clr[w_head.wa] = 1'b1;
    end

    // Scoreboard update; set and clear of different registers both apply.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_busy <= '0;
        else         r_busy <= (r_busy & ~w_clr) | w_set;
    end

    // Count cycles the primary blocks a non-empty FIFO; saturates at the limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                         r_starve_cnt <= '0;
        else if (w_empty || w_pop)           r_starve_cnt <= '0;
        else if (r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + SW'(1);
    end

    assign starve_stall = (r_starve_cnt == STARVE_MAX);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with hand-computed expectations.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        resetn;
    logic        p_valid;
    logic [4:0]  p_wa;
    logic [31:0] p_wd;
    logic        s_valid;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    logic        s_ready;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic        iss_ready;
    logic [4:0]  q_ra1;
    logic [4:0]  q_ra2;
    logic [4:0]  q_wa;
    logic        hazard_stall;
    logic        starve_stall;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        write_enable;

    int n_chk  = 0;
    int n_fail = 0;
    int n_viol = 0;
    logic [31:0] sh_busy;

    logic [4:0]  wr_wa [10];
    logic [31:0] wr_wd [10];

    regfile_wb_scheduler #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .p_valid      (p_valid),
        .p_wa         (p_wa),
        .p_wd         (p_wd),
        .s_valid      (s_valid),
        .s_wa         (s_wa),
        .s_wd         (s_wd),
        .s_ready      (s_ready),
        .iss_valid    (iss_valid),
        .iss_wa       (iss_wa),
        .iss_ready    (iss_ready),
        .q_ra1        (q_ra1),
        .q_ra2        (q_ra2),
        .q_wa         (q_wa),
        .hazard_stall (hazard_stall),
        .starve_stall (starve_stall),
        .wa3          (wa3),
        .wd3          (wd3),
        .write_enable (write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        p_valid = 0; p_wa = 0; p_wd = 0;
        s_valid = 0; s_wa = 0; s_wd = 0;
        iss_valid = 0; iss_wa = 0;
        q_ra1 = 0; q_ra2 = 0; q_wa = 0;
    endtask

    // Flags primary writes to reserved registers (legal for the DUT, a protocol error upstream).
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_busy <= '0;
        end else begin
            if (p_valid && p_wa != 0 && sh_busy[p_wa]) begin
                n_viol++;
                $display("NOTE primary write to reserved r%0d", p_wa);
            end
            if (iss_valid && iss_ready && iss_wa != 0) sh_busy[iss_wa] <= 1'b1;
            if (!p_valid && write_enable)              sh_busy[wa3]    <= 1'b0;
        end
    end

    initial begin
        idle();
        resetn = 0;
        settle();
        chk("rst_we",     {31'b0, write_enable}, 32'd0);
        chk("rst_wa3",    {27'b0, wa3},          32'd0);
        chk("rst_wd3",    wd3,                   32'd0);
        chk("rst_sready", {31'b0, s_ready},      32'd1);
        chk("rst_iready", {31'b0, iss_ready},    32'd1);
        chk("rst_haz",    {31'b0, hazard_stall}, 32'd0);
        chk("rst_starve", {31'b0, starve_stall}, 32'd0);
        tick(); tick();
        resetn = 1;
        tick();

        // Priority: FIFO head (7,0x22) is held while primary writes r3.
        iss_valid = 1; iss_wa = 7; s_valid = 1; s_wa = 7; s_wd = 32'h22;
        settle();
        chk("pri_iss7", {31'b0, iss_ready}, 32'd1);
        chk("pri_we0",  {31'b0, write_enable}, 32'd0);
        tick();
        idle(); p_valid = 1; p_wa = 3; p_wd = 32'h11; q_ra1 = 7;
        settle();
        chk("pri_wa_p",  {27'b0, wa3}, 32'd3);
        chk("pri_wd_p",  wd3, 32'h11);
        chk("pri_we_p",  {31'b0, write_enable}, 32'd1);
        chk("pri_haz7",  {31'b0, hazard_stall}, 32'd1);
        tick();
        p_valid = 0; p_wa = 0; p_wd = 0;
        settle();
        chk("pri_wa_s",  {27'b0, wa3}, 32'd7);
        chk("pri_wd_s",  wd3, 32'h22);
        chk("pri_we_s",  {31'b0, write_enable}, 32'd1);
        chk("pri_haz_hold", {31'b0, hazard_stall}, 32'd1);
        tick();
        settle();
        chk("pri_haz_clr", {31'b0, hazard_stall}, 32'd0);
        chk("pri_idle_we", {31'b0, write_enable}, 32'd0);

        // Reservation of r9, released by a secondary write.
        idle(); iss_valid = 1; iss_wa = 9; q_ra1 = 9;
        settle();
        chk("res_iss9", {31'b0, iss_ready}, 32'd1);
        chk("res_haz_c0", {31'b0, hazard_stall}, 32'd0);
        tick();
        iss_valid = 0;
        settle();
        chk("res_haz_c1", {31'b0, hazard_stall}, 32'd1);
        tick();
        q_ra1 = 0; q_ra2 = 9;
        settle();
        chk("res_haz_c2_ra2", {31'b0, hazard_stall}, 32'd1);
        tick();
        s_valid = 1; s_wa = 9; s_wd = 32'hABCD;
        settle();
        chk("res_no_bypass", {31'b0, write_enable}, 32'd0);
        tick();
        s_valid = 0; q_ra2 = 0; q_wa = 9;
        settle();
        chk("res_wa9", {27'b0, wa3}, 32'd9);
        chk("res_wd9", wd3, 32'hABCD);
        chk("res_we9", {31'b0, write_enable}, 32'd1);
        chk("res_haz_c4_wa", {31'b0, hazard_stall}, 32'd1);
        tick();
        settle();
        chk("res_haz_c5", {31'b0, hazard_stall}, 32'd0);

        // WAW on r4, register 0 reservation and secondary write to r0.
        idle(); iss_valid = 1; iss_wa = 4;
        settle();
        chk("waw_first", {31'b0, iss_ready}, 32'd1);
        tick();
        settle();
        chk("waw_second", {31'b0, iss_ready}, 32'd0);
        tick();
        iss_wa = 0; q_wa = 0;
        settle();
        chk("waw_r0_ready", {31'b0, iss_ready}, 32'd1);
        chk("waw_r0_haz", {31'b0, hazard_stall}, 32'd0);
        tick();
        idle(); q_ra2 = 4; s_valid = 1; s_wa = 0; s_wd = 32'hDEAD;
        settle();
        chk("waw_haz4", {31'b0, hazard_stall}, 32'd1);
        tick();
        s_valid = 0;
        settle();
        chk("s0_we", {31'b0, write_enable}, 32'd0);
        tick();
        s_valid = 1; s_wa = 4; s_wd = 32'h44;
        settle();
        chk("s0_popped", {31'b0, write_enable}, 32'd0);
        chk("s0_haz4_still", {31'b0, hazard_stall}, 32'd1);
        tick();
        s_valid = 0; iss_valid = 1; iss_wa = 4;
        settle();
        chk("waw_wa4", {27'b0, wa3}, 32'd4);
        chk("waw_same_cyc_rej", {31'b0, iss_ready}, 32'd0);
        tick();
        iss_valid = 0;
        settle();
        chk("waw_r4_free", {31'b0, iss_ready}, 32'd1);
        chk("waw_haz_clr", {31'b0, hazard_stall}, 32'd0);

        // Primary write to a reserved register: performed, busy kept.
        idle(); iss_valid = 1; iss_wa = 12;
        tick();
        idle(); p_valid = 1; p_wa = 12; p_wd = 32'h77; q_ra1 = 12;
        settle();
        chk("viol_we", {31'b0, write_enable}, 32'd1);
        chk("viol_wd", wd3, 32'h77);
        tick();
        p_valid = 0; s_valid = 1; s_wa = 12; s_wd = 32'h0;
        settle();
        chk("viol_busy_kept", {31'b0, hazard_stall}, 32'd1);
        tick();
        s_valid = 0;
        tick();
        settle();
        chk("viol_released", {31'b0, hazard_stall}, 32'd0);

        // Full FIFO under a continuous primary stream, then starvation.
        idle(); p_valid = 1; p_wa = 1; p_wd = 32'h1;
        s_valid = 1; s_wa = 10; s_wd = 32'hA0;
        tick();
        s_wa = 11; s_wd = 32'hB1;
        settle();
        chk("full_sready_1", {31'b0, s_ready}, 32'd1);
        tick();
        s_valid = 0;
        settle();
        chk("full_sready_0", {31'b0, s_ready}, 32'd0);
        chk("full_p_wins", {27'b0, wa3}, 32'd1);
        tick(); tick();
        settle();
        chk("starve_c4", {31'b0, starve_stall}, 32'd0);
        tick();
        settle();
        chk("starve_c5", {31'b0, starve_stall}, 32'd1);
        tick();
        settle();
        chk("starve_sat", {31'b0, starve_stall}, 32'd1);
        tick();
        p_valid = 0;
        settle();
        chk("drain0_wa", {27'b0, wa3}, 32'd10);
        chk("drain0_wd", wd3, 32'hA0);
        tick();
        settle();
        chk("drain1_wa", {27'b0, wa3}, 32'd11);
        chk("drain1_wd", wd3, 32'hB1);
        chk("drain_sready", {31'b0, s_ready}, 32'd1);
        chk("drain_starve_clr", {31'b0, starve_stall}, 32'd0);
        tick();
        settle();
        chk("drain_empty", {31'b0, write_enable}, 32'd0);

        // Pointer wrap: reserve and push each cycle, drain one per cycle.
        idle();
        for (int i = 0; i < 10; i++) begin
            wr_wa[i] = 5'(13 + i);
            wr_wd[i] = $urandom;
        end
        for (int i = 0; i < 10; i++) begin
            iss_valid = 1; iss_wa = wr_wa[i];
            s_valid = 1; s_wa = wr_wa[i]; s_wd = wr_wd[i];
            settle();
            chk("wrap_iss", {31'b0, iss_ready}, 32'd1);
            if (i > 0) begin
                chk("wrap_wa", {27'b0, wa3}, {27'b0, wr_wa[i-1]});
                chk("wrap_wd", wd3, wr_wd[i-1]);
            end else begin
                chk("wrap_we0", {31'b0, write_enable}, 32'd0);
            end
            tick();
        end
        idle();
        settle();
        chk("wrap_last_wa", {27'b0, wa3}, {27'b0, wr_wa[9]});
        chk("wrap_last_wd", wd3, wr_wd[9]);
        tick();
        for (int i = 0; i < 10; i++) begin
            iss_wa = wr_wa[i]; q_ra1 = wr_wa[i];
            settle();
            chk("wrap_free", {30'b0, iss_ready, hazard_stall}, 32'd2);
        end

        // Reset while the FIFO holds two entries and r5 is reserved.
        idle(); iss_valid = 1; iss_wa = 5;
        p_valid = 1; p_wa = 2; p_wd = 32'h5;
        s_valid = 1; s_wa = 20; s_wd = 32'h1;
        tick();
        iss_valid = 0; s_wa = 21; s_wd = 32'h2;
        tick();
        idle(); q_ra1 = 5; iss_wa = 5;
        settle();
        chk("mid_pre_wa", {27'b0, wa3}, 32'd20);
        chk("mid_pre_full", {31'b0, s_ready}, 32'd0);
        chk("mid_pre_haz", {31'b0, hazard_stall}, 32'd1);
        #1 resetn = 0;
        settle();
        chk("mid_rst_we", {31'b0, write_enable}, 32'd0);
        chk("mid_rst_sready", {31'b0, s_ready}, 32'd1);
        chk("mid_rst_haz", {31'b0, hazard_stall}, 32'd0);
        chk("mid_rst_iready", {31'b0, iss_ready}, 32'd1);
        tick();
        resetn = 1;
        tick();

        chk("viol_count", n_viol, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
